moving_avg_5: RTL and testbench

- Signed 5-tap boxcar (moving-average) filter with clock enable, used in the receive DSP chain to smooth low-rate sample streams.
- On each enabled cycle it accepts one sample and outputs the mean of the 5 most recent samples.
- Averaging is done with a running sum plus a 5-deep delay line; there is no adder tree.

---
 rtl/moving_avg_pkg.sv | 12 +
 rtl/div_by_5.sv | 42 ++++
 rtl/moving_avg_5.sv | 46 ++++
 tb/tb_moving_avg_5.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/moving_avg_pkg.sv
// Shared constants and width helper for the 5-tap moving-average filter.
package moving_avg_pkg;

  localparam int MA_TAPS       = 5;
  localparam int MA_GUARD_BITS = 3;

  // Five full-scale samples need three bits of headroom above the sample width.
  function automatic int sum_width(input int data_width);
    return data_width + MA_GUARD_BITS;
  endfunction

endpackage

// File: rtl/div_by_5.sv
// Combinational signed divide-by-5 from running-sum width down to sample width.
// MA5_ROUND_NEAREST_EN selects round-to-nearest (ties away from zero); default truncates toward zero.
module div_by_5
  import moving_avg_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SUM_W      = sum_width(DATA_WIDTH)
) (
  input  logic signed [SUM_W-1:0]      sum,
  output logic signed [DATA_WIDTH-1:0] quot
);

  localparam int RW = SUM_W + 1;
  localparam logic signed [SUM_W-1:0] DIVISOR   = SUM_W'(MA_TAPS);
  localparam logic signed [RW-1:0]    DIVISOR_R = RW'(MA_TAPS);
  localparam logic signed [RW-1:0]    HALF      = RW'(MA_TAPS / 2);

  // The quotient magnitude never exceeds the largest input sample, so the
  // narrowing cast discards only sign-extension bits.
  function automatic logic signed [DATA_WIDTH-1:0] div_trunc(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] q;
    q = s / DIVISOR;
    return DATA_WIDTH'(q);
  endfunction

  // Biasing by floor(5/2) away from zero before truncation gives nearest
  // rounding; an exact .5 remainder cannot occur with divisor 5.
  function automatic logic signed [DATA_WIDTH-1:0] div_round(input logic signed [SUM_W-1:0] s);
    logic signed [RW-1:0] biased;
    logic signed [RW-1:0] q;
    biased = (s < 0) ? RW'(s) - HALF : RW'(s) + HALF;
    q      = biased / DIVISOR_R;
    return DATA_WIDTH'(q);
  endfunction

`ifdef MA5_ROUND_NEAREST_EN
  assign quot = div_round(sum);
`else
  assign quot = div_trunc(sum);
`endif

endmodule

// File: rtl/moving_avg_5.sv
// Signed 5-tap boxcar filter: running sum plus 5-deep delay line, one sample per ce.
// Build option MA5_ROUND_NEAREST_EN (in div_by_5) switches the final divide to nearest rounding.
module moving_avg_5
  import moving_avg_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout
);

  localparam int SUM_W = sum_width(DATA_WIDTH);

  logic signed [DATA_WIDTH-1:0] taps [MA_TAPS];
  logic signed [SUM_W-1:0]      sum;
  logic signed [SUM_W-1:0]      new_sum;
  logic signed [DATA_WIDTH-1:0] avg;

  // The oldest tap leaves the window as the new sample enters it.
  assign new_sum = sum + SUM_W'(din) - SUM_W'(taps[MA_TAPS-1]);

  div_by_5 #(
    .DATA_WIDTH(DATA_WIDTH),
    .SUM_W     (SUM_W)
  ) u_div (
    .sum (new_sum),
    .quot(avg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MA_TAPS; i++) taps[i] <= '0;
      sum  <= '0;
      dout <= '0;
    end else if (ce) begin
      taps[0] <= din;
      for (int i = 1; i < MA_TAPS; i++) taps[i] <= taps[i-1];
      sum  <= new_sum;
      dout <= avg;
    end
  end

endmodule

// File: tb/tb_moving_avg_5.sv
// Directed scoreboard bench for moving_avg_5 with a history-window reference model.
module tb_moving_avg_5;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ce;
  logic signed [DW-1:0] din;
  logic signed [DW-1:0] dout;

  int checks   = 0;
  int failures = 0;

  int hist [5];
  logic signed [DW-1:0] exp_q [$];
  logic signed [DW-1:0] last_exp;

  moving_avg_5 #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .din (din),
    .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [DW-1:0] obs,
                       input logic signed [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Mean of the last five samples, derived from the explicit window contents.
  function automatic logic signed [DW-1:0] model_push(input int d);
    int s, q, r;
    for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
    s = 0;
    for (int i = 0; i < 5; i++) s += hist[i];
    q = s / 5;
`ifdef MA5_ROUND_NEAREST_EN
    r = s - q * 5;
    if (2 * r >= 5) q++;
    else if (2 * r <= -5) q--;
`else
    r = 0;
`endif
    return DW'(q + r - r);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++) hist[i] = 0;
  endtask

  task automatic step(input int d);
    logic signed [DW-1:0] e;
    @(negedge clk);
    din = DW'(d);
    ce  = 1'b1;
    exp_q.push_back(model_push(d));
    @(posedge clk);
    #1;
    ce = 1'b0;
    e = exp_q.pop_front();
    last_exp = e;
    check("avg", dout, e);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic step_lit(input int d, input int lit, input string tag);
    step(d);
    check(tag, dout, DW'(lit));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    last_exp = '0;
  endtask

  initial begin
    int plan_a [7];
    int plan_b [5];
    int plan_c [4];
    int plan_d [16];
    int seq_c  [5];
    plan_a = '{3, 6, 9, 12, 15, 15, 15};
    plan_b = '{12, 9, 6, 3, 0};
    seq_c  = '{10, 15, 0, -15, -10};
    plan_c = '{2, 5, 5, 2};
    plan_d = '{-3, -6, -9, -12, -15, -15, -15, -15, -9, -3, 3, 9, 15, 15, 15, 15};

    rst = 1'b1;
    ce  = 1'b0;
    din = '0;
    model_clear();
    last_exp = '0;
    #12;
    check("reset_dout", dout, '0);
    @(negedge clk);
    rst = 1'b0;

    // Constant 15 ramps up, then zeros ramp down.
    for (int i = 0; i < 7; i++) step_lit(15, plan_a[i], "ramp_up");
    for (int i = 0; i < 5; i++) step_lit(0, plan_b[i], "ramp_down");

    // ce low: random din must not disturb the output.
    step(7);
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      din = DW'($urandom);
      if (i % 33 == 32) check("hold", dout, last_exp);
    end

    // Periodic sequence from fresh history.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 5; i++)
        step_lit(seq_c[i], (p == 0 && i < 4) ? plan_c[i] : 0, "periodic");

    // Negative plateau then step to positive.
    do_reset();
    for (int i = 0; i < 16; i++) step_lit(i < 8 ? -15 : 15, plan_d[i], "neg_to_pos");

    // Division direction on a single sample.
    do_reset();
`ifdef MA5_ROUND_NEAREST_EN
    step_lit(13, 3, "pos13");
    do_reset();
    step_lit(-13, -3, "neg13");
`else
    step_lit(13, 2, "pos13");
    do_reset();
    step_lit(-13, -2, "neg13");
`endif

    // Asynchronous reset mid-stream.
    step(40);
    step(-25);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", dout, '0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    step_lit(15, 3, "after_rst");

    // Full scale in both directions.
    do_reset();
    for (int i = 0; i < 5; i++) step(32767);
    check("full_pos", dout, 16'sd32767);
    for (int i = 0; i < 5; i++) step(-32768);
    check("full_neg", dout, -16'sd32768);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
